// File: rtl/e20_mem_pkg.sv
// Shared types and constants for the E20 memory arbiter.
// Feature macro used by the arbiter: E20_ARB_PERF_EN (performance counters).
package e20_mem_pkg;

  localparam int MEM_WORDS    = 8192;
  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 16;
  localparam int NREQ         = 3;
  localparam int STARVE_LIMIT = 4;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DEBUG = 2;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [15:0]       addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/e20_prio_grant.sv
// Fixed-priority grant for fetch/data/debug.
// Promote lifts fetch above data; debug always wins.
module e20_prio_grant
  import e20_mem_pkg::*;
(
  input  logic [NREQ-1:0] valid_i,
  input  logic            promote_i,
  output logic [NREQ-1:0] gnt_o
);

  // One-hot grant, highest priority valid requester wins
  always_comb begin
    gnt_o = '0;
    if (valid_i[REQ_DEBUG]) begin
      gnt_o[REQ_DEBUG] = 1'b1;
    end else if (promote_i && valid_i[REQ_FETCH]) begin
      gnt_o[REQ_FETCH] = 1'b1;
    end else if (valid_i[REQ_DATA]) begin
      gnt_o[REQ_DATA] = 1'b1;
    end else if (valid_i[REQ_FETCH]) begin
      gnt_o[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/e20_mem_arbiter.sv
// E20 unified RAM arbiter: fetch, data and debug share one port.
// Optional E20_ARB_PERF_EN adds grant/stall counters and perf_sel/perf_data.
module e20_mem_arbiter
  import e20_mem_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   freeze,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*16-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   starve_flag
`ifdef E20_ARB_PERF_EN
  ,
  input  logic [2:0]             perf_sel,
  output logic [31:0]            perf_data
`endif
);

  mem_req_t        req [NREQ];
  mem_req_t        sel;
  logic [NREQ-1:0] vmask;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [DATA_W-1:0] rdata_q;
  logic [2:0]      cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic            unused_bits;

  // Unpack the flat request buses
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req[i].valid = req_valid[i];
      req[i].we    = req_we[i];
      req[i].addr  = req_addr[16*i +: 16];
      req[i].wdata = req_wdata[DATA_W*i +: DATA_W];
    end
  end

  // Freeze hides the core ports; reset hides everything
  assign vmask = {req_valid[REQ_DEBUG],
                  req_valid[REQ_DATA:REQ_FETCH] & {2{~freeze}}}
               & {NREQ{~reset}};

  e20_prio_grant u_prio (
    .valid_i   (vmask),
    .promote_i (flag_q),
    .gnt_o     (gnt)
  );

  assign req_ready = gnt;

  // Route the granted request to the RAM
  always_comb begin
    sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel = req[i];
    end
  end

  assign mem_en    = |gnt;
  assign mem_we    = sel.we;
  assign mem_addr  = sel.addr[ADDR_W-1:0];
  assign mem_wdata = sel.wdata;

  // Top address bits wrap modulo 8192
  assign unused_bits = ^{sel.valid, sel.addr[15:ADDR_W]};

  // Next-state for pending read, starve counter and promote flag
  always_comb begin
    pend_d = gnt & ~req_we;
    cnt_d  = cnt_q;
    if (!req_valid[REQ_FETCH] || gnt[REQ_FETCH]) begin
      cnt_d = '0;
    end else if (!freeze && cnt_q != 3'b111) begin
      cnt_d = cnt_q + 3'd1;
    end
    flag_d = flag_q;
    if (gnt[REQ_FETCH]) begin
      flag_d = 1'b0;
    end else if (cnt_d >= 3'(STARVE_LIMIT)) begin
      flag_d = 1'b1;
    end
  end

  // Arbiter state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      if (|pend_q) rdata_q <= mem_rdata;
    end
  end

  assign rsp_valid   = pend_q;
  assign rsp_rdata   = (|pend_q) ? mem_rdata : rdata_q;
  assign starve_flag = flag_q;

`ifdef E20_ARB_PERF_EN
  logic [31:0] gcnt_q [NREQ];
  logic [31:0] scnt_q [NREQ];
  logic [31:0] gcnt_d [NREQ];
  logic [31:0] scnt_d [NREQ];
  logic [NREQ-1:0] stall;

  assign stall = req_valid & ~gnt;

  // Wrapping grant/stall counter increments
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      gcnt_d[i] = gcnt_q[i] + 32'(gnt[i]);
      scnt_d[i] = scnt_q[i] + 32'(stall[i]);
    end
  end

  // Counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        gcnt_q[i] <= '0;
        scnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        gcnt_q[i] <= gcnt_d[i];
        scnt_q[i] <= scnt_d[i];
      end
    end
  end

  // Counter readout select
  always_comb begin
    perf_data = '0;
    case (perf_sel)
      3'd0:    perf_data = gcnt_q[0];
      3'd1:    perf_data = gcnt_q[1];
      3'd2:    perf_data = gcnt_q[2];
      3'd3:    perf_data = scnt_q[0];
      3'd4:    perf_data = scnt_q[1];
      3'd5:    perf_data = scnt_q[2];
      default: perf_data = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_e20_mem_arbiter.sv
// Self-checking bench for e20_mem_arbiter.
// Table vectors plus hand sequences; read responses go through a scoreboard.
module tb_e20_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        freeze;
  logic [2:0]  req_valid, req_we;
  logic [47:0] req_addr, req_wdata;
  logic [2:0]  req_ready, rsp_valid;
  logic [15:0] rsp_rdata;
  logic        mem_en, mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        starve_flag;
`ifdef E20_ARB_PERF_EN
  logic [2:0]  perf_sel;
  logic [31:0] perf_data;
`endif

  logic [15:0] a [3];
  logic [15:0] wd [3];
  logic [15:0] ram [8192];
  logic [15:0] exp_mem [8192];

  assign req_addr  = {a[2], a[1], a[0]};
  assign req_wdata = {wd[2], wd[1], wd[0]};

  e20_mem_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .freeze      (freeze),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .starve_flag (starve_flag)
`ifdef E20_ARB_PERF_EN
    ,
    .perf_sel    (perf_sel),
    .perf_data   (perf_data)
`endif
  );

  always #5 clock = ~clock;

  // RAM macro model: one-cycle read latency
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  typedef struct {
    int          due;
    int          port;
    logic [15:0] data;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic        frz;
    logic [2:0]  v;
    logic [2:0]  we;
    logic [15:0] a0, a1, a2;
    logic [15:0] wd1, wd2;
    logic [2:0]  er;
    logic        ef;
  } vec_t;
  vec_t tbl[12];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic        have_last = 1'b0;
  logic [15:0] last_rd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic frz, input logic [2:0] v,
                       input logic [2:0] we, input logic [15:0] a0,
                       input logic [15:0] a1, input logic [15:0] a2,
                       input logic [15:0] wd1, input logic [15:0] wd2);
    freeze    = frz;
    req_valid = v;
    req_we    = we;
    a[0] = a0; a[1] = a1; a[2] = a2;
    wd[0] = 16'h0; wd[1] = wd1; wd[2] = wd2;
  endtask

  // Check one cycle of outputs, then advance to the next negedge
  task automatic exp_cycle(input logic [2:0] er, input logic ef,
                           input string tag);
    int g;
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'(er));
    chk({tag, " flag"}, 32'(starve_flag), 32'(ef));
    chk({tag, " mem_en"}, 32'(mem_en), 32'(er != 3'b000));
    g = -1;
    for (int i = 0; i < 3; i++) if (er[i]) g = i;
    if (g >= 0) begin
      chk({tag, " mem_addr"}, 32'(mem_addr), 32'(a[g] & 16'h1FFF));
      chk({tag, " mem_we"}, 32'(mem_we), 32'(req_we[g]));
      if (req_we[g]) begin
        chk({tag, " mem_wdata"}, 32'(mem_wdata), 32'(wd[g]));
        exp_mem[a[g] & 16'h1FFF] = wd[g];
      end else begin
        sbq.push_back('{due: cyc + 1, port: g,
                        data: exp_mem[a[g] & 16'h1FFF]});
      end
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(1 << sbq[0].port));
      chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(sbq[0].data));
      last_rd = sbq[0].data;
      have_last = 1'b1;
      void'(sbq.pop_front());
    end else begin
      chk({tag, " rsp_idle"}, 32'(rsp_valid), 32'd0);
      if (have_last) chk({tag, " rsp_hold"}, 32'(rsp_rdata), 32'(last_rd));
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b0;
    sbq.delete();
    have_last = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = 16'(i) ^ 16'h5A5A;
      exp_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    ram[3]     = 16'hABCD;
    exp_mem[3] = 16'hABCD;
`ifdef E20_ARB_PERF_EN
    perf_sel = 3'd0;
`endif

    tbl[0]  = '{0, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b000, 0};
    tbl[1]  = '{0, 3'b001, 3'b000, 16'h0003, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b001, 0};
    tbl[2]  = '{0, 3'b010, 3'b000, 16'h0000, 16'h0007, 16'h0000,
                16'h0000, 16'h0000, 3'b010, 0};
    tbl[3]  = '{1, 3'b111, 3'b100, 16'h0003, 16'h0007, 16'h2010,
                16'h0000, 16'h1234, 3'b100, 0};
    tbl[4]  = '{1, 3'b011, 3'b000, 16'h0003, 16'h0007, 16'h0000,
                16'h0000, 16'h0000, 3'b000, 0};
    tbl[5]  = '{0, 3'b001, 3'b000, 16'h0010, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b001, 0};
    tbl[6]  = '{0, 3'b011, 3'b010, 16'h2005, 16'h0005, 16'h0000,
                16'hBEEF, 16'h0000, 3'b010, 0};
    tbl[7]  = '{0, 3'b001, 3'b000, 16'h2005, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b001, 0};
    tbl[8]  = '{0, 3'b111, 3'b000, 16'h0001, 16'h0002, 16'h0003,
                16'h0000, 16'h0000, 3'b100, 0};
    tbl[9]  = '{0, 3'b011, 3'b000, 16'h0001, 16'h0002, 16'h0000,
                16'h0000, 16'h0000, 3'b010, 0};
    tbl[10] = '{0, 3'b001, 3'b000, 16'h0001, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b001, 0};
    tbl[11] = '{0, 3'b000, 3'b000, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 3'b000, 0};

    // Reset state, with all requesters asserting valid
    reset = 1'b1;
    drive(0, 3'b111, 3'b000, 16'h1, 16'h2, 16'h3, 0, 0);
    @(negedge clock);
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst flag", 32'(starve_flag), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    reset = 1'b0;
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    @(negedge clock);

    // Table vectors
    for (int k = 0; k < 12; k++) begin
      drive(tbl[k].frz, tbl[k].v, tbl[k].we, tbl[k].a0, tbl[k].a1,
            tbl[k].a2, tbl[k].wd1, tbl[k].wd2);
      exp_cycle(tbl[k].er, tbl[k].ef, $sformatf("vec%0d", k));
    end

    // Starvation: fetch and data held continuously
    for (int k = 0; k < 6; k++) begin
      drive(0, 3'b011, 3'b000, 16'h0003, 16'(16'h20 + k), 0, 0, 0);
      exp_cycle((k == 4) ? 3'b001 : 3'b010, k == 4,
                $sformatf("starve%0d", k));
    end
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    exp_cycle(3'b000, 0, "starve_idle");

    // Starvation counting pauses while frozen
    for (int k = 0; k < 7; k++) begin
      logic       fz;
      logic [2:0] er;
      fz = (k == 3 || k == 4);
      er = fz ? 3'b000 : ((k == 6) ? 3'b001 : 3'b010);
      drive(fz, 3'b011, 3'b000, 16'h0004, 16'(16'h40 + k), 0, 0, 0);
      exp_cycle(er, k == 6, $sformatf("frzstarve%0d", k));
    end
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    exp_cycle(3'b000, 0, "frzstarve_idle");

    // Reset while a data read is in flight
    drive(0, 3'b010, 3'b000, 0, 16'h0007, 0, 0, 0);
    exp_cycle(3'b010, 0, "rstrd grant");
    reset = 1'b1;
    #1;
    chk("rstrd rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstrd ready", 32'(req_ready), 32'd0);
    chk("rstrd mem_en", 32'(mem_en), 32'd0);
    sbq.delete();
    have_last = 1'b0;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset = 1'b0;
    drive(0, 3'b001, 3'b000, 16'h0003, 0, 0, 0, 0);
    exp_cycle(3'b001, 0, "rstrd fetch");
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    exp_cycle(3'b000, 0, "rstrd idle");

    // Contention from a clean reset; requesters drop once served
    reset_pulse();
    drive(0, 3'b111, 3'b000, 16'h0003, 16'h0004, 16'h0005, 0, 0);
    exp_cycle(3'b100, 0, "cont0");
    drive(0, 3'b011, 3'b000, 16'h0003, 16'h0004, 16'h0005, 0, 0);
    exp_cycle(3'b010, 0, "cont1");
    drive(0, 3'b001, 3'b000, 16'h0003, 16'h0004, 16'h0005, 0, 0);
    exp_cycle(3'b001, 0, "cont2");
    drive(0, 3'b000, 3'b000, 0, 0, 0, 0, 0);
    exp_cycle(3'b000, 0, "cont3");

`ifdef E20_ARB_PERF_EN
    begin
      logic [31:0] pexp [8];
      pexp = '{32'd1, 32'd1, 32'd1, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
      for (int s = 0; s < 8; s++) begin
        perf_sel = 3'(s);
        #1;
        chk($sformatf("perf%0d", s), perf_data, pexp[s]);
      end
    end
`endif

    chk("sb empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/e20_mem_arbiter.md
Name: e20_mem_arbiter

Overview:
Arbitrates the E20 unified 8192x16 single-port RAM between three requesters: instruction fetch (port 0), data load/store (port 1) and the debug/program loader (port 2).
Sits between the processor core, the debug loader and the RAM macro.
Enforces fixed priority with anti-starvation aging for fetch, and a debug freeze that stalls the core's memory traffic.
Returns read data one cycle after grant.

Parameters:
NREQ, 3, number of requesters (fixed at 3; index 0=fetch, 1=data, 2=debug)
ADDR_W, 13, RAM address width (8192 words)
DATA_W, 16, word width
STARVE_LIMIT, 4, consecutive denied cycles before fetch is promoted above data

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
freeze  in  1  debug freeze; while high, requesters 0 and 1 are never granted
req_valid  in  NREQ  request valid per requester
req_we  in  NREQ  1 = write, 0 = read
req_addr  in  NREQ*16  E20 16-bit addresses, packed, requester i at [16i+15:16i]
req_wdata  in  NREQ*DATA_W  write data, packed
req_ready  out  NREQ  one-hot grant; a request completes in a cycle where valid & ready
rsp_valid  out  NREQ  one-hot; read data for requester i is valid this cycle
rsp_rdata  out  DATA_W  shared read-data bus
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after a read with mem_en
starve_flag  out  1  fetch is currently promoted

Behaviour:
- Reset (asynchronous): req_ready=0, rsp_valid=0, starve counter=0, starve_flag=0, pending-read register cleared. mem_en/we are combinational from grant, so they are 0 while reset is high. Any read in flight at reset is dropped, with no rsp_valid.
- Grant is combinational from the current req_valid, freeze and starve_flag. At most one req_ready bit is high per cycle.
- Priority: debug > data > fetch. When starve_flag=1: debug > fetch > data.
- Freeze masks req_valid[0] and req_valid[1] before arbitration. Starve counting pauses while freeze is high.
- A granted request drives mem_en=1, mem_we=req_we[g], mem_addr=req_addr[g][12:0], mem_wdata=req_wdata[g].
  - Upper address bits [15:13] are ignored (modulo-8192 wrap, E20 semantics); address 0x2005 hits word 5.
- Read response: the grant index is registered. The next cycle, rsp_valid[g]=1 and rsp_rdata=mem_rdata.
  - Writes produce no response.
  - Back-to-back grants are allowed every cycle, giving full throughput.
- rsp_rdata holds its last value when rsp_valid=0.
- Starve counter (3 bits, saturating), per cycle:
  - If req_valid[0] & ~req_ready[0] & ~freeze: increment.
  - If ready[0] is granted or req_valid[0]=0: clear to 0.
  - starve_flag is set when the counter reaches STARVE_LIMIT, and cleared on the cycle after the fetch grant.
- Requesters must hold valid, addr, we and wdata stable until ready. The arbiter does not register requests.
- Same-cycle write by port 1 and read by port 0 to the same address: only one is granted. The fetch sees the written value on its later grant.

Optional Feature:
E20_ARB_PERF_EN:
- Defined: adds per-requester 32-bit grant counters and stall counters (valid & ~ready), both wrapping. Also adds input perf_sel[2:0] and output perf_data[31:0].
  - perf_sel 0..2 selects the grant count of requester 0..2.
  - perf_sel 3..5 selects the stall count of requester 0..2.
  - 6..7 read 0.
  - Counters reset to 0.
- Undefined: no counters, and the perf_sel/perf_data ports are absent. Arbitration is identical.

Decomposition:
- Package e20_mem_pkg:
  - MEM_WORDS=8192, ADDR_W, DATA_W
  - requester index constants REQ_FETCH=0, REQ_DATA=1, REQ_DEBUG=2
  - typedef mem_req_t {valid, we, addr[15:0], wdata[15:0]}
- Sub-module e20_prio_grant: combinational 3-way priority encoder with a promote input. This keeps the top level as registers plus muxing.

Test Plan:
- Single port: fetch reads addr 0x0003 holding 0xABCD. Expect req_ready[0] in cycle N, then rsp_valid=3'b001 and rsp_rdata=0xABCD in N+1.
- Contention: all three valid in the same cycle. Expect grant order debug, data, fetch over 3 cycles, and rsp_valid following each read by one cycle.
- Starvation: fetch and data held valid continuously.
  - Expect 4 data grants, then starve_flag=1 and a fetch grant in cycle 5.
  - Expect starve_flag=0 in cycle 6 and data resuming.
- Freeze: freeze=1 with fetch and data valid. Expect no grant and mem_en=0. A debug write of 0x1234 to addr 0x2010 is granted with mem_addr=0x0010. Starve counter stays 0.
- Reset mid-read: assert reset in the cycle after a data read grant. Expect rsp_valid=0 immediately. After release, the first request is served normally.
- E20_ARB_PERF_EN: run the contention scenario. Expect grant counts 1,1,1 and stall counts 2,1,0 for fetch, data, debug.
